// File: rtl/fibonacci_lfsr_checker_if.sv
// Word stream from the 5-bit Fibonacci LFSR generator to its checker.
//   in_valid : in_data carries a generator word this cycle
//   in_data  : generator word
// master drives the stream (generator side), slave consumes it (checker side).
interface fibonacci_lfsr_checker_if;
  logic       in_valid;
  logic [4:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/fibonacci_lfsr_checker.sv
// Receive-side checker for the 5-bit Fibonacci LFSR word stream.
// Locks after LOCK_COUNT consecutive predicted words. While locked it flags and
// counts mispredicted words, and it returns to search after ERR_LIMIT
// consecutive misses.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   in_if      : word stream (in_valid, in_data[4:0])
//   clr_count  : synchronous clear of err_count and zero_seen
//   locked     : checker is locked onto the sequence
//   err_pulse  : one-cycle pulse per mismatch while locked
//   err_count  : saturating count of mismatches while locked
//   zero_seen  : sticky, an all-zero word was received
module fibonacci_lfsr_checker #(
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned ERR_LIMIT  = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  fibonacci_lfsr_checker_if.slave       in_if,
  input  logic                          clr_count,
  output logic                          locked,
  output logic                          err_pulse,
  output logic [CNT_W-1:0]              err_count,
  output logic                          zero_seen
);

  localparam int unsigned W  = 5;
  localparam int unsigned MW = 4;

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [MW-1:0]    LOCK_TGT = MW'(LOCK_COUNT);
  localparam logic [MW-1:0]    ERR_TGT  = MW'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Generator advances five shifts per emitted word.
  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] w);
    logic [W-1:0] s;
    s = w;
    for (int i = 0; i < 5; i++) s = {s[4] ^ s[1], s[4:1]};
    return s;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [W-1:0]     prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [MW-1:0]    match_q, match_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic             locked_d, err_pulse_d, zero_seen_d;
  logic [CNT_W-1:0] err_count_d;

  logic [W-1:0]     expected;
  logic [MW-1:0]    match_inc, miss_inc;
  logic             is_zero, hit;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    // Clear applies first so a same-cycle event still lands on top of it.
    err_count_d = clr_count ? '0 : err_count;
    zero_seen_d = clr_count ? 1'b0 : zero_seen;

    expected  = lfsr_next(prev_q);
    match_inc = match_q + MW'(1);
    miss_inc  = miss_q + MW'(1);
    is_zero   = (in_if.in_data == '0);
    hit       = (in_if.in_data == expected);

    if (in_if.in_valid) begin
      if (state_q == ST_LOCKED) begin
        if (hit) begin
          prev_d = in_if.in_data;
          miss_d = '0;
        end else begin
          err_pulse_d = 1'b1;
          if (err_count_d != CNT_MAX) err_count_d = err_count_d + CNT_W'(1);
          miss_d = miss_inc;
          // Flywheel on the prediction so one bad word does not desync.
          prev_d = expected;
          if (is_zero) zero_seen_d = 1'b1;
          if (miss_inc == ERR_TGT) begin
            state_d     = ST_SEARCH;
            match_d     = '0;
            prev_d      = in_if.in_data;
            have_prev_d = 1'b1;
          end
        end
      end else begin
        prev_d      = in_if.in_data;
        have_prev_d = 1'b1;
        // Zero is a fixed point of the LFSR, so it never counts toward lock.
        if (is_zero) begin
          match_d     = '0;
          zero_seen_d = 1'b1;
        end else if (have_prev_q && hit) begin
          match_d = match_inc;
          if (match_inc == LOCK_TGT) begin
            state_d = ST_LOCKED;
            miss_d  = '0;
          end
        end else begin
          match_d = '0;
        end
      end
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SEARCH;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      match_q     <= '0;
      miss_q      <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      zero_seen   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked      <= locked_d;
      err_pulse   <= err_pulse_d;
      err_count   <= err_count_d;
      zero_seen   <= zero_seen_d;
    end
  end

endmodule

// File: tb/tb_fibonacci_lfsr_checker.sv
// Directed bench for fibonacci_lfsr_checker. Two instances share the input
// stream: u_dut with default parameters, u_sat with a 2-bit counter and a
// large error limit for saturation.
module tb_fibonacci_lfsr_checker;

  logic       clk;
  logic       rst_n;
  logic       clr_count;
  logic       locked, err_pulse, zero_seen;
  logic [7:0] err_count;
  logic       s_locked, s_err_pulse, s_zero_seen;
  logic [1:0] s_err_count;

  int n_chk  = 0;
  int n_pass = 0;

  fibonacci_lfsr_checker_if bus ();

  fibonacci_lfsr_checker u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_if     (bus),
    .clr_count (clr_count),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .zero_seen (zero_seen)
  );

  fibonacci_lfsr_checker #(.LOCK_COUNT(3), .ERR_LIMIT(15), .CNT_W(2)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_if     (bus),
    .clr_count (clr_count),
    .locked    (s_locked),
    .err_pulse (s_err_pulse),
    .err_count (s_err_count),
    .zero_seen (s_zero_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Drive one cycle of stimulus at negedge; return just after the next posedge.
  task automatic step(input logic v, input logic [4:0] d, input logic c);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    clr_count    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    clr_count    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [4:0] lock_seq [4] = '{5'h1f, 5'h1a, 5'h04, 5'h1e};
  logic [1:0] sat_exp  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [7:0] main_exp [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4};

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    clr_count    = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.in_data  = 5'($urandom);
      clr_count    = 1'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_pulse", 32'(err_pulse), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_zero_seen", 32'(zero_seen), 0);

    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    clr_count    = 1'b0;
    rst_n        = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 5'h00, 1'b0);
    chk("idle_locked", 32'(locked), 0);
    chk("idle_outputs", 32'({err_pulse, zero_seen, err_count}), 0);

    // Lock on 1f,1a,04,1e.
    for (int i = 0; i < 3; i++) step(1'b1, lock_seq[i], 1'b0);
    chk("lock_not_yet", 32'(locked), 0);
    step(1'b1, 5'h1e, 1'b0);
    chk("lock_rise", 32'(locked), 1);
    chk("lock_err_count", 32'(err_count), 0);
    step(1'b1, 5'h1a, 1'b0); chk("run_pulse_a", 32'(err_pulse), 0);
    step(1'b1, 5'h04, 1'b0); chk("run_pulse_b", 32'(err_pulse), 0);
    step(1'b1, 5'h1e, 1'b0); chk("run_pulse_c", 32'(err_pulse), 0);

    // Single corrupted word: flywheel keeps sync.
    step(1'b1, 5'h05, 1'b0);
    chk("single_pulse", 32'(err_pulse), 1);
    chk("single_count", 32'(err_count), 1);
    chk("single_locked", 32'(locked), 1);
    step(1'b1, 5'h04, 1'b0);
    chk("single_pulse_off", 32'(err_pulse), 0);
    chk("single_count_hold", 32'(err_count), 1);
    step(1'b1, 5'h1e, 1'b0);
    chk("single_relocked", 32'({locked, err_pulse}), 32'b10);

    // Gap in in_valid does not break the sequence.
    step(1'b0, 5'h11, 1'b0);
    step(1'b0, 5'h11, 1'b0);
    step(1'b1, 5'h1a, 1'b0);
    chk("gap_match", 32'({locked, err_pulse}), 32'b10);

    // Clear, then sustained errors drop lock on the 4th.
    step(1'b0, 5'h00, 1'b1);
    chk("clr_count", 32'(err_count), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'h05, 1'b0);
      chk("loss_pulse", 32'(err_pulse), 1);
      chk("loss_count", 32'(err_count), 32'(i + 1));
      chk("loss_locked", 32'(locked), (i == 3) ? 0 : 1);
    end
    // prev is now 05, f(05)=1e, so 1a starts a fresh run.
    step(1'b1, 5'h1a, 1'b0);
    chk("search_no_pulse", 32'(err_pulse), 0);
    step(1'b1, 5'h04, 1'b0);
    step(1'b1, 5'h1e, 1'b0);
    chk("relock_not_yet", 32'(locked), 0);
    step(1'b1, 5'h1a, 1'b0);
    chk("relock", 32'(locked), 1);
    chk("relock_count", 32'(err_count), 4);

    // Zero words in SEARCH.
    do_reset();
    step(1'b1, 5'h1f, 1'b0);
    step(1'b1, 5'h1a, 1'b0);
    chk("zero_pre", 32'(zero_seen), 0);
    step(1'b1, 5'h00, 1'b0);
    chk("zero_set", 32'(zero_seen), 1);
    step(1'b1, 5'h00, 1'b0);
    step(1'b1, 5'h00, 1'b0);
    chk("zero_no_lock", 32'(locked), 0);
    chk("zero_sticky", 32'(zero_seen), 1);
    step(1'b0, 5'h00, 1'b1);
    chk("zero_clr", 32'(zero_seen), 0);

    // Clear racing a mismatch in LOCKED.
    for (int i = 0; i < 4; i++) step(1'b1, lock_seq[i], 1'b0);
    chk("lock2", 32'(locked), 1);
    step(1'b1, 5'h05, 1'b0);
    step(1'b1, 5'h04, 1'b0);
    chk("pre_clr_count", 32'(err_count), 1);
    step(1'b1, 5'h05, 1'b1);
    chk("clr_mismatch_count", 32'(err_count), 1);
    chk("clr_mismatch_pulse", 32'(err_pulse), 1);
    step(1'b1, 5'h00, 1'b1);
    chk("clr_zero_locked", 32'({locked, zero_seen, err_pulse}), 32'b111);
    chk("clr_zero_count", 32'(err_count), 1);

    // Saturation on u_sat; u_dut drops lock alongside.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, lock_seq[i], 1'b0);
    chk("sat_lock", 32'({s_locked, locked}), 32'b11);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5'h05, 1'b0);
      chk("sat_count", 32'(s_err_count), 32'(sat_exp[i]));
      chk("sat_locked", 32'(s_locked), 1);
      chk("main_count", 32'(err_count), 32'(main_exp[i]));
      chk("main_pulse", 32'(err_pulse), (i == 4) ? 0 : 1);
    end
    chk("main_unlocked", 32'(locked), 0);

    // Relock u_dut, then async reset between clock edges.
    step(1'b1, 5'h1a, 1'b0);
    step(1'b1, 5'h04, 1'b0);
    step(1'b1, 5'h1e, 1'b0);
    step(1'b1, 5'h1a, 1'b0);
    chk("pre_async_locked", 32'(locked), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_locked", 32'({locked, s_locked}), 0);
    chk("async_counts", 32'({err_count, s_err_count}), 0);
    chk("async_flags", 32'({zero_seen, s_zero_seen, err_pulse, s_err_pulse}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
